// File: rtl/bad_text_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bad_text_pkg
// Description : Shared types and character constants for the banned-token
//               scanner (lexical regions, lexer states, ASCII codes).
//               Optional macro BAD_TEXT_STRING_EN enables string literals.
// Revision    : 1.0 - initial release
// ============================================================================
package bad_text_pkg;

   typedef enum logic [1:0] {
      LINE_CMT  = 2'd0,
      BLOCK_CMT = 2'd1,
      CODE      = 2'd2,
      STRING    = 2'd3
   } region_e;

   typedef enum logic [2:0] {
      ST_CODE       = 3'd0,
      ST_SLASH      = 3'd1,
      ST_LINE_CMT   = 3'd2,
      ST_BLOCK_CMT  = 3'd3,
      ST_BLOCK_STAR = 3'd4,
      ST_STR        = 3'd5,
      ST_STR_ESC    = 3'd6
   } state_e;

   localparam logic [7:0] CH_X      = 8'h58;
   localparam logic [7:0] CH_SLASH  = 8'h2F;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_NL     = 8'h0A;
   localparam logic [7:0] CH_QUOTE  = 8'h22;
   localparam logic [7:0] CH_BSLASH = 8'h5C;

   // Next lexer state for a character handled as plain code.
   function automatic state_e code_next(input logic [7:0] ch);
      state_e nxt;
      nxt = ST_CODE;
      if (ch == CH_SLASH) begin
         nxt = ST_SLASH;
      end
`ifdef BAD_TEXT_STRING_EN
      else if (ch == CH_QUOTE) begin
         nxt = ST_STR;
      end
`endif
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bad_text_pos_tracker.sv
`default_nettype none
// ============================================================================
// Module      : bad_text_pos_tracker
// Description : 1-based line/column of the next character to be accepted.
//               Both counters wrap; end of file restores (1,1).
// Revision    : 1.0 - initial release
// ============================================================================
module bad_text_pos_tracker
   import bad_text_pkg::*;
#(
   parameter int LINE_W = 16,
   parameter int COL_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic [7:0]        char_in,
   input  logic              eof,
   output logic [LINE_W-1:0] line,
   output logic [COL_W-1:0]  col
);

   // Advance on each accepted character; newline moves to the next line.
   always_ff @(posedge clk) begin
      if (rst || eof) begin
         line <= LINE_W'(1);
         col  <= COL_W'(1);
      end else if (advance) begin
         if (char_in == CH_NL) begin
            line <= line + LINE_W'(1);
            col  <= COL_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bad_text_scanner.sv
`default_nettype none
// ============================================================================
// Module      : bad_text_scanner
// Description : Streams source bytes, tracks the lexical region and reports
//               every non-overlapping "XXX" with its region and position.
//               Optional macro BAD_TEXT_STRING_EN adds string-literal region.
// Revision    : 1.0 - initial release
// ============================================================================
module bad_text_scanner
   import bad_text_pkg::*;
#(
   parameter int LINE_W = 16,
   parameter int COL_W  = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_char,
   input  logic              in_last,
   output logic              hit_valid,
   input  logic              hit_ready,
   output logic [1:0]        hit_kind,
   output logic [LINE_W-1:0] hit_line,
   output logic [COL_W-1:0]  hit_col,
   output logic              done,
   output logic [CNT_W-1:0]  hit_count
);

   state_e            state, state_nxt;
   region_e           region, prev_region;
   logic [1:0]        match, match_nxt;
   logic              hit_now;
   logic              accept, eof;
   logic [LINE_W-1:0] line;
   logic [COL_W-1:0]  col;
   logic [CNT_W-1:0]  count_base;

   assign in_ready = !hit_valid || hit_ready;
   assign accept   = in_valid && in_ready;
   assign eof      = accept && in_last;

   bad_text_pos_tracker #(
      .LINE_W (LINE_W),
      .COL_W  (COL_W)
   ) u_pos (
      .clk     (clk),
      .rst     (rst),
      .advance (accept),
      .char_in (in_char),
      .eof     (eof),
      .line    (line),
      .col     (col)
   );

   // Lexer state register; end of file always returns to code.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CODE;
      end else if (accept) begin
         state <= eof ? ST_CODE : state_nxt;
      end
   end

   // Lexer next state and the region the current character belongs to.
   always_comb begin
      state_nxt = state;
      region    = CODE;
      case (state)
         ST_CODE: begin
            region    = CODE;
            state_nxt = code_next(in_char);
         end
         ST_SLASH: begin
            region = CODE;
            if (in_char == CH_SLASH) begin
               state_nxt = ST_LINE_CMT;
            end else if (in_char == CH_STAR) begin
               state_nxt = ST_BLOCK_CMT;
            end else begin
               state_nxt = code_next(in_char);
            end
         end
         ST_LINE_CMT: begin
            region = LINE_CMT;
            if (in_char == CH_NL) state_nxt = ST_CODE;
         end
         ST_BLOCK_CMT: begin
            region = BLOCK_CMT;
            if (in_char == CH_STAR) state_nxt = ST_BLOCK_STAR;
         end
         ST_BLOCK_STAR: begin
            region = BLOCK_CMT;
            if (in_char == CH_SLASH) begin
               state_nxt = ST_CODE;
            end else if (in_char != CH_STAR) begin
               state_nxt = ST_BLOCK_CMT;
            end
         end
`ifdef BAD_TEXT_STRING_EN
         ST_STR: begin
            region = STRING;
            if (in_char == CH_BSLASH) begin
               state_nxt = ST_STR_ESC;
            end else if (in_char == CH_QUOTE) begin
               state_nxt = ST_CODE;
            end
         end
         ST_STR_ESC: begin
            region    = STRING;
            state_nxt = ST_STR;
         end
`endif
         default: begin
            state_nxt = ST_CODE;
         end
      endcase
   end

   // Run-of-X counter: a region change restarts the run at this character.
   always_comb begin
      match_nxt = 2'd0;
      hit_now   = 1'b0;
      if (in_char == CH_X) begin
         if (region == prev_region) begin
            if (match == 2'd2) begin
               hit_now   = 1'b1;
               match_nxt = 2'd0;
            end else begin
               match_nxt = match + 2'd1;
            end
         end else begin
            match_nxt = 2'd1;
         end
      end
   end

   // Match counter and previous-region register.
   always_ff @(posedge clk) begin
      if (rst) begin
         match       <= 2'd0;
         prev_region <= CODE;
      end else if (accept) begin
         match       <= eof ? 2'd0 : match_nxt;
         prev_region <= eof ? CODE : region;
      end
   end

   // Hit record: loaded on a hit, held until the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_valid <= 1'b0;
         hit_kind  <= 2'd0;
         hit_line  <= '0;
         hit_col   <= '0;
      end else if (accept && hit_now) begin
         hit_valid <= 1'b1;
         hit_kind  <= region;
         hit_line  <= line;
         hit_col   <= col;
      end else if (hit_ready) begin
         hit_valid <= 1'b0;
      end
   end

   // The count is shown with done, then cleared for the next file.
   assign count_base = done ? '0 : hit_count;

   // End-of-file pulse and saturating per-file hit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         done      <= 1'b0;
         hit_count <= '0;
      end else begin
         done <= eof;
         if (accept && hit_now) begin
            hit_count <= (&count_base) ? count_base : count_base + CNT_W'(1);
         end else begin
            hit_count <= count_base;
         end
      end
   end

endmodule
`default_nettype wire
